// File: rtl/mem_byte_responder.sv
// mem_byte_responder
//   Responder end of the cache-to-memory request interface. Takes one
//   1/2/4-byte read or write request at a time and turns it into byte-wide
//   accesses on an external RAM with registered (1-cycle latency) read data.
//   Read bytes are assembled little-endian and returned zero-extended.
//
//   Handshake: a request is accepted on a clock edge where rdy_in=1, the
//   block is IDLE (ready=1) and waiting=1. The requester parameters are
//   sampled only at that edge. ready stays low until the request completes.
//   After completion ready is high for at least one cycle, and a request
//   still waiting at that point is accepted at the next edge.
//
// Ports
//   clk_in, rst_in : clock, synchronous active-high reset
//   rdy_in         : global enable; low pauses byte issue (reads still capture)
//   mem_din        : RAM read data, valid the cycle after its address
//   mem_dout       : RAM write data
//   mem_a          : RAM byte address
//   mem_wr         : RAM write strobe, one cycle per written byte
//   waiting        : requester has a pending request
//   wr, len        : request type (1 = write), log2 of byte count (2..7 -> 4)
//   addr, value    : request start address, write data (byte i = value[8i+:8])
//   ready          : idle / result valid
//   result         : read data, zero-extended
//   fsm_state      : current FSM state, for observation
module mem_byte_responder #(
   parameter int ADDR_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              waiting,
   input  logic              wr,
   input  logic [2:0]        len,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       value,
   output logic              ready,
   output logic [31:0]       result,
   output logic [1:0]        fsm_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY_RD = 2'd1,
      S_BUSY_WR = 2'd2
   } state_t;

   state_t            state_q, state_n;
   logic [2:0]        n_q, n_n;          // byte count: 1, 2 or 4
   logic [2:0]        cnt_q, cnt_n;      // index of next byte to issue
   logic [ADDR_W-1:0] base_q, base_n;
   logic [31:0]       value_q, value_n;
   // Two-stage pending pipe: the RAM registers the address one edge after
   // issue, so the data is on mem_din one edge later still.
   logic              p0_q, p0_n, p1_q, p1_n;
   logic [1:0]        p0_slot_q, p0_slot_n, p1_slot_q, p1_slot_n;
   logic [31:0]       asm_q, asm_n;
   logic [31:0]       result_q, result_n;
   logic              ready_q, ready_n;
   logic [ADDR_W-1:0] mem_a_q, mem_a_n;
   logic [7:0]        mem_dout_q, mem_dout_n;
   logic              mem_wr_q, mem_wr_n;

   logic              issue, issue_wr;
   logic [1:0]        issue_idx;
   logic [ADDR_W-1:0] src_addr;
   logic [31:0]       src_value;

   always_comb begin
      state_n    = state_q;
      n_n        = n_q;
      cnt_n      = cnt_q;
      base_n     = base_q;
      value_n    = value_q;
      p0_n       = 1'b0;
      p0_slot_n  = p0_slot_q;
      p1_n       = p0_q;
      p1_slot_n  = p0_slot_q;
      asm_n      = asm_q;
      result_n   = result_q;
      ready_n    = ready_q;
      mem_a_n    = mem_a_q;
      mem_dout_n = mem_dout_q;
      mem_wr_n   = 1'b0;             // never repeat a write on a stall edge
      issue      = 1'b0;
      issue_wr   = 1'b0;
      issue_idx  = cnt_q[1:0];
      src_addr   = base_q;
      src_value  = value_q;

      // Read capture happens whether or not rdy_in is high.
      if (p1_q) begin
         asm_n[8*p1_slot_q +: 8] = mem_din;
      end

      case (state_q)
         S_IDLE: begin
            if (rdy_in && waiting) begin
               issue     = 1'b1;
               issue_wr  = wr;
               issue_idx = 2'd0;
               src_addr  = addr;
               src_value = value;
               base_n    = addr;
               value_n   = value;
               n_n       = (len == 3'd0) ? 3'd1 : ((len == 3'd1) ? 3'd2 : 3'd4);
               cnt_n     = 3'd1;
               asm_n     = '0;
               ready_n   = 1'b0;
               state_n   = wr ? S_BUSY_WR : S_BUSY_RD;
            end
         end
         S_BUSY_WR: begin
            if (rdy_in) begin
               if (cnt_q < n_q) begin
                  issue    = 1'b1;
                  issue_wr = 1'b1;
                  cnt_n    = cnt_q + 3'd1;
               end else begin
                  ready_n = 1'b1;
                  state_n = S_IDLE;
               end
            end
         end
         S_BUSY_RD: begin
            if (rdy_in && (cnt_q < n_q)) begin
               issue = 1'b1;
               cnt_n = cnt_q + 3'd1;
            end
            // Bytes are captured in order, so capturing the last slot ends it.
            if (p1_q && ({1'b0, p1_slot_q} == (n_q - 3'd1))) begin
               result_n = asm_n;
               ready_n  = 1'b1;
               state_n  = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase

      if (issue) begin
         mem_a_n = src_addr + {{(ADDR_W-2){1'b0}}, issue_idx};
         if (issue_wr) begin
            mem_wr_n   = 1'b1;
            mem_dout_n = src_value[8*issue_idx +: 8];
         end else begin
            p0_n      = 1'b1;
            p0_slot_n = issue_idx;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         cnt_q      <= '0;
         base_q     <= '0;
         value_q    <= '0;
         p0_q       <= 1'b0;
         p0_slot_q  <= '0;
         p1_q       <= 1'b0;
         p1_slot_q  <= '0;
         asm_q      <= '0;
         result_q   <= '0;
         ready_q    <= 1'b1;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
         mem_wr_q   <= 1'b0;
      end else begin
         state_q    <= state_n;
         n_q        <= n_n;
         cnt_q      <= cnt_n;
         base_q     <= base_n;
         value_q    <= value_n;
         p0_q       <= p0_n;
         p0_slot_q  <= p0_slot_n;
         p1_q       <= p1_n;
         p1_slot_q  <= p1_slot_n;
         asm_q      <= asm_n;
         result_q   <= result_n;
         ready_q    <= ready_n;
         mem_a_q    <= mem_a_n;
         mem_dout_q <= mem_dout_n;
         mem_wr_q   <= mem_wr_n;
      end
   end

   assign mem_a     = mem_a_q;
   assign mem_dout  = mem_dout_q;
   assign mem_wr    = mem_wr_q;
   assign ready     = ready_q;
   assign result    = result_q;
   assign fsm_state = state_q;

endmodule

// File: tb/tb_mem_byte_responder.sv
// Directed bench for mem_byte_responder with a byte RAM model that has
// registered read data (1-cycle latency) and decodes address bits 17:0.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mem_byte_responder;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        waiting;
   logic        wr;
   logic [2:0]  len;
   logic [31:0] addr;
   logic [31:0] value;
   logic        ready;
   logic [31:0] result;
   logic [1:0]  fsm_state;

   int vectors     = 0;
   int miscompares = 0;

   // clock / reset
   always #5 clk_in = ~clk_in;

   mem_byte_responder #(.ADDR_W(32)) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .rdy_in    (rdy_in),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout),
      .mem_a     (mem_a),
      .mem_wr    (mem_wr),
      .waiting   (waiting),
      .wr        (wr),
      .len       (len),
      .addr      (addr),
      .value     (value),
      .ready     (ready),
      .result    (result),
      .fsm_state (fsm_state)
   );

   // RAM model; preload port is used only while the DUT is idle
   logic [7:0]  ram [0:262143];
   logic        pre_we = 1'b0;
   logic [17:0] pre_a  = '0;
   logic [7:0]  pre_d  = '0;

   always @(posedge clk_in) begin
      if (pre_we) ram[pre_a] <= pre_d;
      else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
      mem_din <= ram[mem_a[17:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [17:0] a, input logic [7:0] d);
      pre_a  = a;
      pre_d  = d;
      pre_we = 1'b1;
      @(negedge clk_in);
      pre_we = 1'b0;
   endtask

   // Present a request, let it be accepted, then drop waiting.
   // Returns at the falling edge after the accept edge.
   task automatic do_req(input logic w, input logic [2:0] l, input logic [31:0] a,
                         input logic [31:0] v);
      waiting = 1'b1;
      wr      = w;
      len     = l;
      addr    = a;
      value   = v;
      @(posedge clk_in);
      @(negedge clk_in);
      waiting = 1'b0;
   endtask

   // Counts edges after the accept edge until ready is seen (bounded).
   task automatic wait_ready(input int start, output int c);
      c = start;
      while (ready !== 1'b1 && c < 60) begin
         @(negedge clk_in);
         c++;
      end
   endtask

   int c;

   initial begin
      rst_in  = 1'b1;
      rdy_in  = 1'b1;
      waiting = 1'b0;
      wr      = 1'b0;
      len     = 3'd0;
      addr    = '0;
      value   = '0;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      check("rst_ready", {31'b0, ready}, 32'd1);
      check("rst_result", result, 32'h0);
      check("rst_mem_a", mem_a, 32'h0);
      check("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
      check("rst_mem_dout", {24'b0, mem_dout}, 32'h0);
      check("rst_state", {30'b0, fsm_state}, 32'd0);

      // word read at 0x100
      preload(18'h100, 8'h13);
      preload(18'h101, 8'h05);
      preload(18'h102, 8'h00);
      preload(18'h103, 8'h00);
      preload(18'h104, 8'h7E);
      do_req(1'b0, 3'd2, 32'h100, 32'h0);
      for (int k = 0; k < 4; k++) begin
         check("rd_walk_a", mem_a, 32'h100 + k);
         check("rd_walk_wr", {31'b0, mem_wr}, 32'd0);
         check("rd_walk_busy", {31'b0, ready}, 32'd0);
         @(negedge clk_in);
      end
      check("rd_e4_busy", {31'b0, ready}, 32'd0);
      @(negedge clk_in);
      check("rd_e5_ready", {31'b0, ready}, 32'd1);
      check("rd_result", result, 32'h0000_0513);

      // byte write to IO address
      do_req(1'b1, 3'd0, 32'h30000, 32'h41);
      check("io_wr", {31'b0, mem_wr}, 32'd1);
      check("io_a", mem_a, 32'h30000);
      check("io_dout", {24'b0, mem_dout}, 32'h41);
      @(negedge clk_in);
      check("io_wr_drop", {31'b0, mem_wr}, 32'd0);
      check("io_ready", {31'b0, ready}, 32'd1);
      check("io_result_kept", result, 32'h0000_0513);
      check("io_ram", {24'b0, ram[18'h30000]}, 32'h41);

      // halfword write then read back
      do_req(1'b1, 3'd1, 32'h200, 32'h0000_BEEF);
      check("hw_a0", mem_a, 32'h200);
      check("hw_d0", {24'b0, mem_dout}, 32'hEF);
      check("hw_wr0", {31'b0, mem_wr}, 32'd1);
      @(negedge clk_in);
      check("hw_a1", mem_a, 32'h201);
      check("hw_d1", {24'b0, mem_dout}, 32'hBE);
      check("hw_wr1", {31'b0, mem_wr}, 32'd1);
      @(negedge clk_in);
      check("hw_wr_end", {31'b0, mem_wr}, 32'd0);
      check("hw_ready", {31'b0, ready}, 32'd1);
      do_req(1'b0, 3'd1, 32'h200, 32'h0);
      wait_ready(0, c);
      check("hr_latency", c, 32'd3);
      check("hr_result", result, 32'h0000_BEEF);

      // halfword write wrapping the address space
      do_req(1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0000_1234);
      check("wrap_a0", mem_a, 32'hFFFF_FFFF);
      check("wrap_d0", {24'b0, mem_dout}, 32'h34);
      @(negedge clk_in);
      check("wrap_a1", mem_a, 32'h0);
      check("wrap_d1", {24'b0, mem_dout}, 32'h12);
      wait_ready(1, c);
      check("wrap_latency", c, 32'd2);

      // word read at 0 with a 3-cycle stall after byte 1 (len=5 -> 4 bytes)
      preload(18'h0, 8'h11);
      preload(18'h1, 8'h22);
      preload(18'h2, 8'h33);
      preload(18'h3, 8'h44);
      do_req(1'b0, 3'd5, 32'h0, 32'h0);
      @(negedge clk_in);
      check("st_a1", mem_a, 32'h1);
      rdy_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_in);
         check("st_hold_a", mem_a, 32'h1);
         check("st_hold_wr", {31'b0, mem_wr}, 32'd0);
         check("st_hold_busy", {31'b0, ready}, 32'd0);
      end
      rdy_in = 1'b1;
      wait_ready(4, c);
      check("st_latency", c, 32'd8);
      check("st_result", result, 32'h4433_2211);
      check("st_last_a", mem_a, 32'h3);

      // reset in the middle of a word write
      preload(18'h400, 8'h00);
      preload(18'h401, 8'h00);
      do_req(1'b1, 3'd2, 32'h400, 32'hA1B2_C3D4);
      check("rw_wr0", {31'b0, mem_wr}, 32'd1);
      check("rw_d0", {24'b0, mem_dout}, 32'hD4);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      check("rw_ready", {31'b0, ready}, 32'd1);
      check("rw_mem_wr", {31'b0, mem_wr}, 32'd0);
      check("rw_result", result, 32'h0);
      check("rw_state", {30'b0, fsm_state}, 32'd0);
      check("rw_ram0", {24'b0, ram[18'h400]}, 32'hD4);
      check("rw_ram1", {24'b0, ram[18'h401]}, 32'h00);
      do_req(1'b0, 3'd0, 32'h400, 32'h0);
      wait_ready(0, c);
      check("rw_rd_latency", c, 32'd2);
      check("rw_rd_result", result, 32'hD4);

      // back-to-back: waiting held across completion of a byte read
      preload(18'h3FFFF, 8'h5A);
      waiting = 1'b1;
      wr      = 1'b0;
      len     = 3'd0;
      addr    = 32'hFFFF_FFFF;
      @(posedge clk_in);
      @(negedge clk_in);
      check("bb_a0", mem_a, 32'hFFFF_FFFF);
      addr = 32'h104;
      @(negedge clk_in);
      check("bb_busy", {31'b0, ready}, 32'd0);
      @(negedge clk_in);
      check("bb_ready", {31'b0, ready}, 32'd1);
      check("bb_result1", result, 32'h5A);
      @(negedge clk_in);
      check("bb_ready_drop", {31'b0, ready}, 32'd0);
      check("bb_a1", mem_a, 32'h104);
      waiting = 1'b0;
      wait_ready(3, c);
      check("bb_latency", c, 32'd5);
      check("bb_result2", result, 32'h7E);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_byte_responder.md
Name: mem_byte_responder

Overview:
- Responder end of the cache-to-memory request interface.
- Accepts one 1/2/4-byte read or write request at a time from the cache arbiter.
- Serializes each request into byte-wide accesses on the external RAM bus (registered read data, 1-cycle latency).
- Returns assembled little-endian read data with a ready level.

Parameters:
ADDR_W, 32, width of the request address and the mem_a bus (RAM decodes bits 17:0 only)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-high
rdy_in  input  1  global enable; low pauses request progress
mem_din  input  8  RAM read data, valid the cycle after its address is presented
mem_dout  output  8  RAM write data
mem_a  output  32  RAM byte address
mem_wr  output  1  RAM write strobe (1 = write)
waiting  input  1  requester has a pending request
wr  input  1  request type (1 = write)
len  input  3  log2 of byte count: 0 = 1 byte, 1 = 2 bytes, 2..7 = 4 bytes
addr  input  32  request start byte address
value  input  32  write data; byte i = value[8i+7:8i]
ready  output  1  1 = idle, able to accept a request; result valid after a read
result  output  32  read data, zero-extended to 32 bits

Behaviour:
- Reset: state IDLE, ready=1, result=0, mem_a=0, mem_dout=0, mem_wr=0, counters and pending flag cleared. Reset mid-transaction abandons it; bytes already written remain in RAM.
- States:
  - IDLE, BUSY_RD, BUSY_WR.
  - All outputs are registered.
- Accept:
  - Condition: edge with rdy_in=1, state IDLE, waiting=1.
  - Latch wr, n (1/2/4), addr, value. ready<=0.
  - Issue byte 0 at the same edge.
  - waiting/params ignored while busy; dropping waiting mid-transaction does not abort it.
- Issue of byte i:
  - mem_a <= addr+i; 32-bit add, wraps 0xFFFFFFFF -> 0x00000000.
  - Write: mem_wr <= 1, mem_dout <= value byte i.
  - Read: mem_wr <= 0, pending slot <= i.
- mem_wr is 1 for exactly one cycle per written byte. Any edge that issues no write byte sets mem_wr <= 0, including stall edges, so IO addresses (e.g. 0x30000) are never written twice.
- Read capture:
  - At every edge where the pending flag is set, mem_din goes into result-assembly byte slot = pending slot.
  - This happens regardless of rdy_in; the pending flag is then cleared unless a new byte is issued at that edge.
- Stall:
  - When rdy_in=0, no byte is issued and the state, counters and mem_a hold; only the pending capture above occurs.
  - Progress resumes at the next edge with rdy_in=1.
- Write completion: the edge after the last byte's issue edge sets ready<=1 and returns to IDLE. With no stalls, ready is high n cycles after the accept edge.
- Read completion:
  - The edge that captures the last byte loads result with the assembled bytes; unread upper bytes are 0.
  - That edge sets ready<=1 and returns to IDLE.
  - With no stalls, ready is high n+1 cycles after the accept edge.
- result holds its value until the next read completes; writes never change result.
- Back-to-back: ready is high for at least 1 cycle. If waiting is still 1 at the first edge in IDLE, a new request is accepted there. The requester must drop waiting the cycle it sees ready=1 unless it intends a new request.
- Idle: mem_wr=0 and mem_a holds its last value.

Test Plan:
- Word read at addr=0x100, RAM[0x100..0x103]=13 05 00 00 -> mem_a walks 0x100..0x103 on consecutive cycles, mem_wr always 0, result=0x00000513, ready rises 5 cycles after accept.
- Byte write at addr=0x30000, value=0x00000041 -> exactly one cycle with mem_wr=1, mem_a=0x30000, mem_dout=0x41; ready=1 one cycle later; result unchanged.
- Halfword write at addr=0x200, value=0x0000BEEF -> cycle 1: 0x200/0xEF, cycle 2: 0x201/0xBE, mem_wr high exactly 2 cycles; halfword read of 0x200 then gives result=0x0000BEEF.
- Word read at 0x0 with rdy_in low for 3 cycles after byte 1 is issued -> no mem_a advance during the stall, no mem_wr pulses, final result equals the uninterrupted case, ready delayed by exactly 3 cycles.
- rst_in asserted on the 2nd cycle of a word write at 0x400 -> exactly one byte written (0x400); next cycle ready=1, mem_wr=0, result=0; a following read is accepted normally.
- waiting held high across completion of a byte read at 0xFFFFFFFF -> mem_a=0xFFFFFFFF; ready high exactly 1 cycle; second request accepted; its first mem_a shows the new addr.
